// File: rtl/cp0_param.sv
// cp0_param: parametrised MIPS coprocessor-0 for the pipelined CPU (SR, Cause, EPC, BadVAddr, PRId,
//   optional Count/Compare timer) with interrupt/exception entry arbitration at the M-stage commit point.
// Latency: requestInt and cp0ReadData are combinational; register updates land on the next clk edge.
//   Reads are not bypassed, so a same-cycle mtc0 is observed one cycle later.
// Backpressure: none; every commit-point request is resolved in the cycle it is presented.
//
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   WE, cp0Addr,         mtc0 write enable, register select (read and write), write data
//   cp0WriteData
//   VPC, BadAddrIn,      commit-point PC, faulting address (ExcCode 4/5),
//   isInDelayedSlot      branch-delay-slot flag of the committing instruction
//   exceptionCode        0 = no exception, otherwise the ExcCode to record
//   HWInt                external interrupt levels, mapped to IP/IM bits [10 +: NUM_HWINT]
//   EXLClr               eret commit, clears SR.EXL
//   cp0ReadData          selected register (0 for unmapped addresses)
//   EPCData              current EPC for the eret redirect
//   requestInt           take an interrupt/exception this cycle (flush/redirect)
//
// Build option: define CP0_TIMER_EN to add Count(9)/Compare(11) and the timer interrupt on IP bit 15.
module cp0_param #(
  parameter int          NUM_HWINT  = 6,
  parameter logic [31:0] PRID_VALUE = 32'h0000_0001
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 WE,
  input  logic [4:0]           cp0Addr,
  input  logic [31:0]          cp0WriteData,
  input  logic [31:0]          VPC,
  input  logic [31:0]          BadAddrIn,
  input  logic                 isInDelayedSlot,
  input  logic [4:0]           exceptionCode,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic                 EXLClr,
  output logic [31:0]          cp0ReadData,
  output logic [31:0]          EPCData,
  output logic                 requestInt
);

  // --------------------------------------------------------------------------
  // Register map
  // --------------------------------------------------------------------------
  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_SR       = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;
`ifdef CP0_TIMER_EN
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
`endif

  // One bit per configured external interrupt line, within the 6-bit IP/IM field.
  function automatic logic [5:0] line_mask();
    logic [5:0] m;
    m = '0;
    for (int i = 0; i < 6; i++) begin
      if (i < NUM_HWINT) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [5:0] LINE_MASK = line_mask();

`ifdef CP0_TIMER_EN
  // The timer shares IP bit 15, so its mask bit must stay writable even when
  // fewer than six external lines are configured.
  localparam logic [5:0] IM_MASK = LINE_MASK | 6'b10_0000;
`else
  localparam logic [5:0] IM_MASK = LINE_MASK;
`endif

  // SR writable bits: IE[0], EXL[1], IM[15:10] (masked); everything else reads 0.
  localparam logic [31:0] SR_WMASK = {16'h0000, IM_MASK, 8'h00, 2'b11};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0] sr_q,        sr_d;
  logic        cause_bd_q,  cause_bd_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [5:0]  cause_ip_q,  cause_ip_d;
  logic [31:0] epc_q,       epc_d;
  logic [31:0] badvaddr_q,  badvaddr_d;

  // --------------------------------------------------------------------------
  // Interrupt / exception qualification
  // --------------------------------------------------------------------------
  logic [5:0]  ip_hw;
  logic [5:0]  ip_live;
  logic        ip_timer;
  logic        sr_ie;
  logic        sr_exl;
  logic [5:0]  sr_im;
  logic        int_req;
  logic        exc_req;
  logic        wr_ok;
  logic        exc_is_addr;
  logic [31:0] epc_target;

  // Zero-extend the configured lines into the 6-bit IP field.
  always_comb begin
    ip_hw = '0;
    for (int i = 0; i < NUM_HWINT; i++) begin
      ip_hw[i] = HWInt[i];
    end
  end

  assign ip_live = {ip_hw[5] | ip_timer, ip_hw[4:0]};

  assign sr_ie  = sr_q[0];
  assign sr_exl = sr_q[1];
  assign sr_im  = sr_q[15:10];

  assign int_req = (|(ip_live & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (exceptionCode != 5'd0) & ~sr_exl;

  // Held low while reset is asserted so the pipeline never flushes on a
  // stale exceptionCode during reset.
  assign requestInt = ~reset & (int_req | exc_req);

  // An mtc0 only lands when no entry and no eret commit is taken this cycle.
  assign wr_ok = WE & ~int_req & ~exc_req & ~EXLClr;

  assign exc_is_addr = (exceptionCode == 5'd4) || (exceptionCode == 5'd5);

  // Delay-slot instructions restart at the branch (modular 32-bit subtract).
  assign epc_target = isInDelayedSlot ? (VPC - 32'd4) : VPC;

  // --------------------------------------------------------------------------
  // Optional Count/Compare timer
  // --------------------------------------------------------------------------
`ifdef CP0_TIMER_EN
  logic [31:0] count_q,      count_d;
  logic [31:0] compare_q,    compare_d;
  logic        timer_pend_q, timer_pend_d;
  logic        timer_hit;

  assign timer_hit = (count_q == compare_q) && (compare_q != 32'd0);

  always_comb begin
    // Count runs (or loads) every cycle, independent of entry priority.
    count_d      = (WE && (cp0Addr == ADDR_COUNT)) ? cp0WriteData : count_q + 32'd1;
    compare_d    = compare_q;
    timer_pend_d = timer_pend_q | timer_hit;
    // A Compare write acknowledges the timer; the clear beats a same-edge hit.
    if (wr_ok && (cp0Addr == ADDR_COMPARE)) begin
      compare_d    = cp0WriteData;
      timer_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= 32'd0;
      compare_q    <= 32'd0;
      timer_pend_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      compare_q    <= compare_d;
      timer_pend_q <= timer_pend_d;
    end
  end

  assign ip_timer = timer_pend_q;
`else
  assign ip_timer = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state: interrupt > exception > eret > mtc0
  // --------------------------------------------------------------------------
  always_comb begin
    sr_d        = sr_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    badvaddr_d  = badvaddr_q;
    // IP is a free-running sample of the live request lines.
    cause_ip_d  = ip_live;

    if (int_req) begin
      sr_d[1]     = 1'b1;
      cause_bd_d  = isInDelayedSlot;
      cause_exc_d = 5'd0;
      epc_d       = epc_target;
    end else if (exc_req) begin
      sr_d[1]     = 1'b1;
      cause_bd_d  = isInDelayedSlot;
      cause_exc_d = exceptionCode;
      epc_d       = epc_target;
      if (exc_is_addr) begin
        badvaddr_d = BadAddrIn;
      end
    end else if (EXLClr) begin
      sr_d[1] = 1'b0;
    end else if (wr_ok) begin
      case (cp0Addr)
        ADDR_SR:  sr_d  = cp0WriteData & SR_WMASK;
        ADDR_EPC: epc_d = {cp0WriteData[31:2], 2'b00};
        default:  ;  // Cause, BadVAddr, PRId, timer and unmapped: no CP0 state here
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q        <= 32'd0;
      cause_bd_q  <= 1'b0;
      cause_exc_q <= 5'd0;
      cause_ip_q  <= 6'd0;
      epc_q       <= 32'd0;
      badvaddr_q  <= 32'd0;
    end else begin
      sr_q        <= sr_d;
      cause_bd_q  <= cause_bd_d;
      cause_exc_q <= cause_exc_d;
      cause_ip_q  <= cause_ip_d;
      epc_q       <= epc_d;
      badvaddr_q  <= badvaddr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read path (purely combinational, no write bypass)
  // --------------------------------------------------------------------------
  always_comb begin
    cp0ReadData = 32'd0;
    case (cp0Addr)
      ADDR_BADVADDR: cp0ReadData = badvaddr_q;
      ADDR_SR:       cp0ReadData = sr_q;
      ADDR_CAUSE:    cp0ReadData = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
      ADDR_EPC:      cp0ReadData = epc_q;
      ADDR_PRID:     cp0ReadData = PRID_VALUE;
`ifdef CP0_TIMER_EN
      ADDR_COUNT:    cp0ReadData = count_q;
      ADDR_COMPARE:  cp0ReadData = compare_q;
`endif
      default:       cp0ReadData = 32'd0;
    endcase
  end

  assign EPCData = epc_q;

endmodule

// File: tb/tb_cp0_param.sv
module tb_cp0_param;

  localparam int          NHW  = 6;
  localparam logic [31:0] PRID = 32'h0000_0001;

  logic           clk = 1'b0;
  logic           reset;
  logic           WE;
  logic [4:0]     cp0Addr;
  logic [31:0]    cp0WriteData;
  logic [31:0]    VPC;
  logic [31:0]    BadAddrIn;
  logic           isInDelayedSlot;
  logic [4:0]     exceptionCode;
  logic [NHW-1:0] HWInt;
  logic           EXLClr;
  logic [31:0]    cp0ReadData;
  logic [31:0]    EPCData;
  logic           requestInt;

  always #5 clk = ~clk;

  cp0_param #(.NUM_HWINT(NHW), .PRID_VALUE(PRID)) dut (
    .clk(clk), .reset(reset), .WE(WE), .cp0Addr(cp0Addr), .cp0WriteData(cp0WriteData),
    .VPC(VPC), .BadAddrIn(BadAddrIn), .isInDelayedSlot(isInDelayedSlot),
    .exceptionCode(exceptionCode), .HWInt(HWInt), .EXLClr(EXLClr),
    .cp0ReadData(cp0ReadData), .EPCData(EPCData), .requestInt(requestInt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: architectural fields of CP0
  logic        m_ie, m_exl, m_bd, m_pend;
  logic [5:0]  m_im, m_ip;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_badv, m_count, m_compare;

  logic [4:0] addr_tab [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0Addr = a;
    #1;
    chk(tag, cp0ReadData, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cp0Addr      = a;
    cp0WriteData = d;
    WE           = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      5'd8:  v = m_badv;
      5'd12: v = {16'd0, m_im, 8'd0, m_exl, m_ie};
      5'd13: v = {m_bd, 15'd0, m_ip, 3'd0, m_exc, 2'd0};
      5'd14: v = m_epc;
      5'd15: v = PRID;
`ifdef CP0_TIMER_EN
      5'd9:  v = m_count;
      5'd11: v = m_compare;
`endif
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0]  ip_live;
    logic        take_int, take_exc, cmp_wr, hit;
    logic [31:0] d;

    reset = 1'b1; WE = 1'b0; cp0Addr = 5'd0; cp0WriteData = 32'd0; VPC = 32'd0;
    BadAddrIn = 32'd0; isInDelayedSlot = 1'b0; exceptionCode = 5'd0; HWInt = '0; EXLClr = 1'b0;

    // Power-on reset
    #12;
    chk_rd("rst_sr", 5'd12, 32'd0);
    chk_rd("rst_cause", 5'd13, 32'd0);
    chk("rst_req", 32'(requestInt), 32'd0);
    reset = 1'b0;
    tick();

    // Reset asserted between edges mid-operation
    wr(5'd12, 32'h0000_FC01);
    chk_rd("sr_wr", 5'd12, 32'h0000_FC01);
    #2;
    exceptionCode = 5'd3; HWInt = 6'h3F; reset = 1'b1;
    #1;
    chk_rd("midrst_sr", 5'd12, 32'd0);
    chk_rd("midrst_epc", 5'd14, 32'd0);
    chk_rd("midrst_cause", 5'd13, 32'd0);
    chk("midrst_req", 32'(requestInt), 32'd0);
    exceptionCode = 5'd0; HWInt = '0; reset = 1'b0;
    tick();

    // Interrupt in delay slot
    wr(5'd12, 32'h0000_1001);
    HWInt = 6'b000100; VPC = 32'h0000_3008; isInDelayedSlot = 1'b1;
    #1;
    chk("int_req", 32'(requestInt), 32'd1);
    tick();
    chk_rd("int_epc", 5'd14, 32'h0000_3004);
    chk_rd("int_cause", 5'd13, 32'h8000_1000);
    chk_rd("int_sr", 5'd12, 32'h0000_1003);
    chk("int_epcdata", EPCData, 32'h0000_3004);
    chk("int_req_exl", 32'(requestInt), 32'd0);
    HWInt = '0; isInDelayedSlot = 1'b0; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    chk_rd("eret_sr", 5'd12, 32'h0000_1001);

    // Interrupt and address exception together: interrupt wins
    HWInt = 6'b000100; exceptionCode = 5'd4; BadAddrIn = 32'hDEAD_BEE0; VPC = 32'h0000_4000;
    #1;
    chk("both_req", 32'(requestInt), 32'd1);
    tick();
    exceptionCode = 5'd0; HWInt = '0;
    chk_rd("both_cause", 5'd13, 32'h0000_1000);
    chk_rd("both_badv", 5'd8, 32'd0);
    chk_rd("both_epc", 5'd14, 32'h0000_4000);
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;

    // Same with the interrupt masked: exception is taken
    wr(5'd12, 32'h0000_0001);
    HWInt = 6'b000100; exceptionCode = 5'd4; BadAddrIn = 32'hDEAD_BEE0; VPC = 32'h0000_5000;
    #1;
    chk("exc_req", 32'(requestInt), 32'd1);
    tick();
    exceptionCode = 5'd0; HWInt = '0;
    chk_rd("exc_cause", 5'd13, 32'h0000_1010);
    chk_rd("exc_badv", 5'd8, 32'hDEAD_BEE0);
    chk_rd("exc_epc", 5'd14, 32'h0000_5000);
    chk_rd("exc_sr", 5'd12, 32'h0000_0003);

    // EXL already set: new exception ignored
    exceptionCode = 5'd10; VPC = 32'h0000_6000; BadAddrIn = 32'd0;
    #1;
    chk("exl_req", 32'(requestInt), 32'd0);
    tick();
    exceptionCode = 5'd0;
    chk_rd("exl_epc", 5'd14, 32'h0000_5000);
    chk_rd("exl_cause", 5'd13, 32'h0000_0010);
    chk_rd("exl_badv", 5'd8, 32'hDEAD_BEE0);

    // eret and mtc0 SR in the same cycle: only EXL clears
    cp0Addr = 5'd12; cp0WriteData = 32'h0000_FC01; WE = 1'b1; EXLClr = 1'b1;
    tick();
    WE = 1'b0; EXLClr = 1'b0;
    chk_rd("eret_we_sr", 5'd12, 32'h0000_0001);

    // EPC alignment, constant and ignored registers
    wr(5'd14, 32'h0000_3007);
    chk_rd("epc_align", 5'd14, 32'h0000_3004);
    chk("epc_align_data", EPCData, 32'h0000_3004);
    chk_rd("prid", 5'd15, PRID);
    chk_rd("unmapped", 5'd3, 32'd0);
    wr(5'd13, 32'hFFFF_FFFF);
    chk_rd("cause_ro", 5'd13, 32'h0000_0010);
    wr(5'd8, 32'h0000_1234);
    chk_rd("badv_ro", 5'd8, 32'hDEAD_BEE0);
    wr(5'd15, 32'h0000_0000);
    chk_rd("prid_ro", 5'd15, PRID);
    wr(5'd12, 32'hFFFF_FFFF);
    chk_rd("sr_mask", 5'd12, 32'h0000_FC03);
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;

    // EPC wrap: VPC=0 in a delay slot
    HWInt = 6'b000001; VPC = 32'd0; isInDelayedSlot = 1'b1;
    tick();
    HWInt = '0; isInDelayedSlot = 1'b0;
    chk_rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    chk_rd("wrap_cause", 5'd13, 32'h8000_0400);
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;

`ifdef CP0_TIMER_EN
    wr(5'd12, 32'h0000_8001);
    wr(5'd11, 32'd5);
    wr(5'd9, 32'd0);
    chk_rd("tmr_count0", 5'd9, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("tmr_req_pre", 32'(requestInt), 32'd0);
      chk_rd("tmr_count", 5'd9, 32'(k));
    end
    tick();
    chk("tmr_req", 32'(requestInt), 32'd1);
    chk_rd("tmr_count6", 5'd9, 32'd6);
    tick();
    chk_rd("tmr_sr", 5'd12, 32'h0000_8003);
    chk_rd("tmr_cause", 5'd13, 32'h0000_8000);
    wr(5'd11, 32'h0000_0100);
    tick();
    chk_rd("tmr_clr_cause", 5'd13, 32'h0000_0000);
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    chk("tmr_clr_req", 32'(requestInt), 32'd0);
    wr(5'd9, 32'hFFFF_FFFF);
    chk_rd("tmr_load", 5'd9, 32'hFFFF_FFFF);
    tick();
    chk_rd("tmr_wrap", 5'd9, 32'd0);
`else
    wr(5'd9, 32'h0000_1234);
    chk_rd("no_count", 5'd9, 32'd0);
    wr(5'd11, 32'd5);
    chk_rd("no_compare", 5'd11, 32'd0);
`endif

    // Randomized phase against the field-level model
    reset = 1'b1;
    #1;
    reset = 1'b0;
    m_ie = 1'b0; m_exl = 1'b0; m_bd = 1'b0; m_pend = 1'b0; m_im = '0; m_ip = '0;
    m_exc = '0; m_epc = '0; m_badv = '0; m_count = '0; m_compare = '0;
    tick();
    m_count = 32'd1;  // one edge elapsed since reset release

    for (int n = 0; n < 400; n++) begin
      WE              = ($urandom_range(0, 2) == 0);
      cp0Addr         = addr_tab[$urandom_range(0, 7)];
      cp0WriteData    = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
      VPC             = $urandom;
      BadAddrIn       = $urandom;
      isInDelayedSlot = 1'($urandom_range(0, 1));
      exceptionCode   = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      HWInt           = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      EXLClr          = ($urandom_range(0, 5) == 0);
      #1;

      ip_live = HWInt;
`ifdef CP0_TIMER_EN
      if (m_pend) ip_live[5] = 1'b1;
`endif
      take_int = m_ie && !m_exl && ((ip_live & m_im) != 6'd0);
      take_exc = (exceptionCode != 5'd0) && !m_exl;

      chk("rnd_req", 32'(requestInt), 32'(take_int || take_exc));
      chk("rnd_rd", cp0ReadData, m_read(cp0Addr));
      chk("rnd_epc", EPCData, m_epc);

      tick();

      d      = cp0WriteData;
      cmp_wr = 1'b0;
      hit    = (m_count == m_compare) && (m_compare != 32'd0);
      if (take_int || take_exc) begin
        m_exl = 1'b1;
        m_bd  = isInDelayedSlot;
        m_epc = isInDelayedSlot ? VPC - 32'd4 : VPC;
        m_exc = take_int ? 5'd0 : exceptionCode;
        if (!take_int && (exceptionCode == 5'd4 || exceptionCode == 5'd5)) m_badv = BadAddrIn;
      end else if (EXLClr) begin
        m_exl = 1'b0;
      end else if (WE) begin
        if (cp0Addr == 5'd12) begin
          m_ie  = d[0];
          m_exl = d[1];
          m_im  = d[15:10];
        end else if (cp0Addr == 5'd14) begin
          m_epc = d & 32'hFFFF_FFFC;
        end else if (cp0Addr == 5'd11) begin
          cmp_wr = 1'b1;
        end
      end
      m_ip = ip_live;
`ifdef CP0_TIMER_EN
      if (cmp_wr) m_compare = d;
      if (cmp_wr)   m_pend = 1'b0;
      else if (hit) m_pend = 1'b1;
      m_count = (WE && cp0Addr == 5'd9) ? d : m_count + 32'd1;
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
